// File: rtl/flag_pkg.sv
// rtl/flag_pkg.sv - shared condition-code encodings, flag bit indices and FSM state type
package flag_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,
    COND_NE = 4'd1,
    COND_CS = 4'd2,
    COND_CC = 4'd3,
    COND_MI = 4'd4,
    COND_PL = 4'd5,
    COND_VS = 4'd6,
    COND_VC = 4'd7,
    COND_HI = 4'd8,
    COND_LS = 4'd9,
    COND_GE = 4'd10,
    COND_LT = 4'd11,
    COND_GT = 4'd12,
    COND_LE = 4'd13,
    COND_AL = 4'd14,
    COND_NV = 4'd15
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/cond_eval.sv
// rtl/cond_eval.sv - combinational condition-code evaluator over an {N,Z,C,V} flag vector
module cond_eval
  import flag_pkg::*;
(
  input  logic [3:0] flags,
  input  cond_e      cond,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_condition_unit.sv
// rtl/flag_condition_unit.sv - NZCV register plus handshaked condition evaluation; FLAG_BYPASS_EN forwards same-cycle flag writes
module flag_condition_unit
  import flag_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flag_we,
  input  logic             z_in,
  input  logic             n_in,
  input  logic             v_in,
  input  logic             c_in,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_cond,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_pass,
  output logic [3:0]       flags_q,
  output logic [CNT_W-1:0] fail_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e     state_q, state_d;
  logic [3:0] flags_in;
  logic [3:0] eval_flags;
  logic       eval_pass;
  logic       accept;

  assign flags_in = {n_in, z_in, c_in, v_in};

`ifdef FLAG_BYPASS_EN
  assign eval_flags = flag_we ? flags_in : flags_q;
`else
  assign eval_flags = flags_q;
`endif

  cond_eval u_cond_eval (
    .flags (eval_flags),
    .cond  (cond_e'(req_cond)),
    .pass  (eval_pass)
  );

  assign req_ready = (state_q == ST_EMPTY) | res_ready;
  assign res_valid = (state_q == ST_FULL);
  assign accept    = req_valid & req_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (req_valid) state_d = ST_FULL;
      ST_FULL:  if (res_ready) state_d = req_valid ? ST_FULL : ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_EMPTY;
      flags_q  <= 4'b0000;
      res_pass <= 1'b0;
      fail_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (flag_we) flags_q <= flags_in;
      // res_pass only moves on acceptance, so a stalled result survives flag writes
      if (accept) begin
        res_pass <= eval_pass;
        if (!eval_pass && fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_flag_condition_unit.sv
// tb/tb_flag_condition_unit.sv - directed vector bench for flag_condition_unit (either FLAG_BYPASS_EN setting)
module tb_flag_condition_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flag_we, z_in, n_in, v_in, c_in;
  logic       req_valid, res_ready;
  logic [3:0] req_cond;

  logic       req_ready, res_valid, res_pass;
  logic [3:0] flags_q;
  logic [7:0] fail_cnt;

  logic       req_ready2, res_valid2, res_pass2;
  logic [3:0] flags_q2;
  logic [1:0] fail_cnt2;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  flag_condition_unit dut (
    .clk(clk), .rst_n(rst_n), .flag_we(flag_we),
    .z_in(z_in), .n_in(n_in), .v_in(v_in), .c_in(c_in),
    .req_valid(req_valid), .req_ready(req_ready), .req_cond(req_cond),
    .res_valid(res_valid), .res_ready(res_ready), .res_pass(res_pass),
    .flags_q(flags_q), .fail_cnt(fail_cnt)
  );

  flag_condition_unit #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .flag_we(flag_we),
    .z_in(z_in), .n_in(n_in), .v_in(v_in), .c_in(c_in),
    .req_valid(req_valid), .req_ready(req_ready2), .req_cond(req_cond),
    .res_valid(res_valid2), .res_ready(res_ready), .res_pass(res_pass2),
    .flags_q(flags_q2), .fail_cnt(fail_cnt2)
  );

  typedef struct {
    logic       we;
    logic [3:0] nzcv;
    logic       rv;
    logic [3:0] cond;
    logic       ev;
    logic       ep;
    logic [3:0] ef;
    int         ec;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic we, input logic [3:0] nzcv, input logic rv,
                     input logic [3:0] cond, input logic ev, input logic ep,
                     input logic [3:0] ef, input int ec);
    vec_t v;
    v.we = we; v.nzcv = nzcv; v.rv = rv; v.cond = cond;
    v.ev = ev; v.ep = ep; v.ef = ef; v.ec = ec;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [3:0] nzcv, input logic rv, input logic [3:0] cond);
    flag_we = we;
    {n_in, z_in, c_in, v_in} = nzcv;
    req_valid = rv;
    req_cond = cond;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    logic       same_pass;
    int         same_cnt;

    rst_n = 1'b0;
    res_ready = 1'b1;
    drive(1'b0, 4'b0000, 1'b0, 4'd0);
    #12;
    chk("reset res_valid", int'(res_valid), 0);
    chk("reset res_pass", int'(res_pass), 0);
    chk("reset flags_q", int'(flags_q), 0);
    chk("reset fail_cnt", int'(fail_cnt), 0);
    chk("reset req_ready", int'(req_ready), 1);
    @(posedge clk);
    #1 rst_n = 1'b1;

`ifdef FLAG_BYPASS_EN
    same_pass = 1'b1; same_cnt = 9;
`else
    same_pass = 1'b0; same_cnt = 10;
`endif

    //   we  nzcv     rv  cond   ev  ep  flags    cnt
    add(0, 4'b0000, 1, 4'd0,  1, 0, 4'b0000, 1);
    add(0, 4'b0000, 1, 4'd1,  1, 1, 4'b0000, 1);
    add(1, 4'b1000, 0, 4'd0,  0, 1, 4'b1000, 1);
    add(0, 4'b0000, 1, 4'd10, 1, 0, 4'b1000, 2);
    add(0, 4'b0000, 1, 4'd11, 1, 1, 4'b1000, 2);
    add(1, 4'b0110, 0, 4'd0,  0, 1, 4'b0110, 2);
    add(0, 4'b0000, 1, 4'd8,  1, 0, 4'b0110, 3);
    add(0, 4'b0000, 1, 4'd9,  1, 1, 4'b0110, 3);
    add(0, 4'b0000, 1, 4'd12, 1, 0, 4'b0110, 4);
    add(0, 4'b0000, 1, 4'd13, 1, 1, 4'b0110, 4);
    add(1, 4'b0011, 0, 4'd0,  0, 1, 4'b0011, 4);
    add(0, 4'b0000, 1, 4'd8,  1, 1, 4'b0011, 4);
    add(0, 4'b0000, 1, 4'd6,  1, 1, 4'b0011, 4);
    add(0, 4'b0000, 1, 4'd7,  1, 0, 4'b0011, 5);
    add(0, 4'b0000, 1, 4'd3,  1, 0, 4'b0011, 6);
    add(0, 4'b0000, 1, 4'd2,  1, 1, 4'b0011, 6);
    add(0, 4'b0000, 1, 4'd4,  1, 0, 4'b0011, 7);
    add(0, 4'b0000, 1, 4'd5,  1, 1, 4'b0011, 7);
    add(0, 4'b0000, 1, 4'd14, 1, 1, 4'b0011, 7);
    add(0, 4'b0000, 1, 4'd15, 1, 0, 4'b0011, 8);
    add(0, 4'b0000, 1, 4'd10, 1, 0, 4'b0011, 9);
    add(1, 4'b0100, 1, 4'd0,  1, same_pass, 4'b0100, same_cnt);

    foreach (vq[i]) begin
      drive(vq[i].we, vq[i].nzcv, vq[i].rv, vq[i].cond);
      step();
      chk($sformatf("vec%0d res_valid", i), int'(res_valid), int'(vq[i].ev));
      chk($sformatf("vec%0d res_pass", i), int'(res_pass), int'(vq[i].ep));
      chk($sformatf("vec%0d flags_q", i), int'(flags_q), int'(vq[i].ef));
      chk($sformatf("vec%0d fail_cnt", i), int'(fail_cnt), vq[i].ec);
    end
    base = same_cnt;

    // Backpressure: hold a failing result while a passing request waits
    drive(1'b0, 4'b0000, 1'b1, 4'd15);
    step();
    chk("bp load res_pass", int'(res_pass), 0);
    chk("bp load fail_cnt", int'(fail_cnt), base + 1);
    res_ready = 1'b0;
    drive(1'b0, 4'b0000, 1'b1, 4'd14);
    #1;
    chk("bp req_ready low", int'(req_ready), 0);
    for (int k = 0; k < 3; k++) begin
      drive(k == 1, 4'b0001, 1'b1, 4'd14);
      step();
      chk($sformatf("bp%0d res_valid", k), int'(res_valid), 1);
      chk($sformatf("bp%0d res_pass", k), int'(res_pass), 0);
      chk($sformatf("bp%0d req_ready", k), int'(req_ready), 0);
      chk($sformatf("bp%0d fail_cnt", k), int'(fail_cnt), base + 1);
    end
    chk("bp flag write landed", int'(flags_q), 4'b0001);
    res_ready = 1'b1;
    #1;
    chk("bp req_ready comb", int'(req_ready), 1);
    step();
    chk("bp release res_pass", int'(res_pass), 1);
    chk("bp release res_valid", int'(res_valid), 1);

    // Saturation on the CNT_W=2 instance
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    drive(1'b0, 4'b0000, 1'b1, 4'd15);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk($sformatf("sat%0d fail_cnt2", k), int'(fail_cnt2), (k > 3) ? 3 : k);
      chk($sformatf("sat%0d fail_cnt", k), int'(fail_cnt), k);
    end

    // Asynchronous reset while FULL
    drive(1'b1, 4'b1111, 1'b1, 4'd15);
    step();
    chk("ar pre res_valid", int'(res_valid), 1);
    chk("ar pre flags_q", int'(flags_q), 4'b1111);
    res_ready = 1'b0;
    drive(1'b0, 4'b0000, 1'b0, 4'd0);
    #3 rst_n = 1'b0;
    #1;
    chk("ar res_valid", int'(res_valid), 0);
    chk("ar flags_q", int'(flags_q), 0);
    chk("ar fail_cnt", int'(fail_cnt), 0);
    chk("ar fail_cnt2", int'(fail_cnt2), 0);
    chk("ar res_pass", int'(res_pass), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/flag_condition_unit.md
# flag_condition_unit

Consumer end of the ALU flag path. Holds the architectural NZCV flag register, loads it from the flag generator's Z/N/V/C outputs on flag-setting instructions, and evaluates 4-bit condition codes for conditional-execution and branch requests through a valid/ready handshake. Sits between the ALU and the control/branch logic. Keeps a saturating count of failed conditions for debug.

## Interface
- CNT_W, 8, width of the failed-condition counter
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- flag_we  input  1  load NZCV this cycle
- z_in, n_in, v_in, c_in  input  1 each  flags from the ALU flag generator
- req_valid  input  1  condition request present
- req_ready  output  1  unit can accept a request
- req_cond  input  4  condition code
- res_valid  output  1  result present
- res_ready  input  1  consumer takes result
- res_pass  output  1  condition true
- flags_q  output  4  current register, {N,Z,C,V}
- fail_cnt  output  CNT_W  saturating count of failed evaluations

## Operation
- Flag register: on clk edge with flag_we=1, flags_q <= {n_in,z_in,c_in,v_in}; otherwise it holds.
- Condition table: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V; 12 GT !Z&(N==V); 13 LE Z|(N!=V); 14 AL 1; 15 NV 0.
- Evaluation flags are selected by FLAG_BYPASS_EN (see Configuration).
- Output FSM, two states:
  - EMPTY: res_valid=0. A request is accepted when req_valid=1; the unit registers res_pass and goes to FULL.
  - FULL: res_valid=1. If res_ready=0, it holds res_pass stable. If res_ready=1 and req_valid=1, it loads the new result and stays in FULL. If res_ready=1 and req_valid=0, it goes to EMPTY.
- req_ready = (state==EMPTY) | res_ready. This is combinational from res_ready; there is no other comb path from inputs to req_ready.
- fail_cnt increments on each accepted request whose result is 0. It saturates at 2^CNT_W-1 and never wraps.
- Reset, asynchronous and effective immediately: flags_q=4'b0000, state=EMPTY, res_valid=0, res_pass=0, fail_cnt=0. A request pending when reset asserts is dropped.

## Timing
- Latency: a request accepted at edge k shows res_valid=1 and res_pass after edge k, one cycle.
- Throughput: one request per cycle while res_ready=1.
- Flag write and request at the same edge: the flags used for evaluation are set by the macro.
- A flag write during FULL with res_ready=0 does not alter the held res_pass.

## Configuration
- FLAG_BYPASS_EN defined: evaluation uses {n_in,z_in,c_in,v_in} when flag_we=1 in the acceptance cycle, and flags_q otherwise. A flag-setting op followed back-to-back by a conditional op sees the new flags.
- FLAG_BYPASS_EN undefined: evaluation always uses flags_q. The control logic must insert one bubble between a flag write and a dependent condition.

## Structure
- Shared package flag_pkg:
  - cond_e enum holding the 16 encodings.
  - Flag bit-index constants: N=3, Z=2, C=1, V=0.
  - fsm state typedef.
- One sub-module, cond_eval: purely combinational. Inputs are 4-bit flags and cond_e; output is pass. It is reused by the decode stage.

## Test plan
- Reset, then req_cond=0 (EQ) with res_ready=1 -> res_pass=0 and fail_cnt=1; then req_cond=1 (NE) -> res_pass=1.
- flag_we=1 with N=1,V=0, then next cycle req_cond=10 (GE) -> res_pass=0; req_cond=11 (LT) -> res_pass=1.
- Same-cycle flag_we=1 (Z=1) and req_cond=0:
  - with FLAG_BYPASS_EN -> res_pass=1.
  - without -> res_pass=0.
- res_ready=0 for 3 cycles with req_valid=1 -> req_ready=0, res_pass stable, and a flag write does not change it; then res_ready=1 -> the next request is accepted the same cycle.
- CNT_W=2, five req_cond=15 (NV) -> fail_cnt=3 after the third and stays 3.
- Assert rst_n=0 mid-FULL -> res_valid=0, flags_q=0, fail_cnt=0 immediately, before the next clock edge.
